// File: rtl/k423_pkg.sv
// Shared types, constants and helpers for the k423 IF front end.
// Core-wide defaults (address width, reset PC) are provided here unless overridden on the command line.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_RST_PC
`define CORE_RST_PC 32'h8000_0000
`endif

package k423_pkg;

  typedef enum logic [1:0] {
    PCGEN_BOOT  = 2'd0,
    PCGEN_RUN   = 2'd1,
    PCGEN_FENCE = 2'd2
  } pcgen_state_e;

  localparam int unsigned PC_INC = 4;

  // Increment a 32-bit event counter, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    logic [31:0] res;
    if (en && (cnt != 32'hFFFF_FFFF)) begin
      res = cnt + 32'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/k423_if_pcgen_perf.sv
// Saturating fetch/prediction/redirect event counters for k423_if_pcgen.
// Only present when K423_PCGEN_PERF_EN is defined.
`ifdef K423_PCGEN_PERF_EN
module k423_if_pcgen_perf
  import k423_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        fetch_inc_i,
  input  logic        prd_tkn_inc_i,
  input  logic        rdr_inc_i,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_prd_tkn_cnt_o,
  output logic [31:0] perf_rdr_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] prd_cnt_q,   prd_cnt_d;
  logic [31:0] rdr_cnt_q,   rdr_cnt_d;

  // Next counter values.
  always_comb begin
    fetch_cnt_d = sat_inc(fetch_cnt_q, fetch_inc_i);
    prd_cnt_d   = sat_inc(prd_cnt_q, prd_tkn_inc_i);
    rdr_cnt_d   = sat_inc(rdr_cnt_q, rdr_inc_i);
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_cnt_q <= 32'd0;
      prd_cnt_q   <= 32'd0;
      rdr_cnt_q   <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      prd_cnt_q   <= prd_cnt_d;
      rdr_cnt_q   <= rdr_cnt_d;
    end
  end

  assign perf_fetch_cnt_o   = fetch_cnt_q;
  assign perf_prd_tkn_cnt_o = prd_cnt_q;
  assign perf_rdr_cnt_o     = rdr_cnt_q;

endmodule
`endif

// File: rtl/k423_if_pcgen.sv
// IF PC generation: holds the fetch PC and picks flush > redirect > fence resume > BTB > PC+4.
// Optional perf counters are enabled with K423_PCGEN_PERF_EN.
module k423_if_pcgen
  import k423_pkg::*;
#(
  parameter int unsigned          ADDR_W = `CORE_ADDR_W,
  parameter logic [ADDR_W-1:0]    RST_PC = ADDR_W'(`CORE_RST_PC)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic [ADDR_W-1:0] prd_src_pc_o,
  input  logic              btb_prd_vld_i,
  input  logic [ADDR_W-1:0] btb_prd_tgt_pc_i,
  output logic              pc_vld_o,
  input  logic              pc_rdy_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_prd_tkn_o,
  output logic [ADDR_W-1:0] pc_prd_tgt_o,
  input  logic              rdr_vld_i,
  input  logic [ADDR_W-1:0] rdr_pc_i,
  input  logic              flush_vld_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              fence_req_i,
  input  logic [ADDR_W-1:0] fence_pc_i,
  input  logic              fence_done_i
`ifdef K423_PCGEN_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_prd_tkn_cnt_o,
  output logic [31:0]       perf_rdr_cnt_o
`endif
);

  pcgen_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fence_pc_q, fence_pc_d;
  logic              acc_s;
  logic [ADDR_W-1:0] btb_tgt_s;
  logic              unused_low_bits_s;

  // Targets are word addresses; the low two bits of every incoming PC are dropped.
  assign btb_tgt_s         = {btb_prd_tgt_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_low_bits_s = ^{btb_prd_tgt_pc_i[1:0], rdr_pc_i[1:0], flush_pc_i[1:0], fence_pc_i[1:0]};
  assign acc_s             = pc_vld_o & pc_rdy_i;

  // State, PC and fence-resume registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= PCGEN_BOOT;
      pc_q       <= RST_PC;
      fence_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fence_pc_q <= fence_pc_d;
    end
  end

  // Next PC / next state selection in priority order.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fence_pc_d = fence_pc_q;
    if (flush_vld_i) begin
      pc_d    = {flush_pc_i[ADDR_W-1:2], 2'b00};
      state_d = PCGEN_RUN;
    end else if (rdr_vld_i) begin
      pc_d    = {rdr_pc_i[ADDR_W-1:2], 2'b00};
      state_d = PCGEN_RUN;
    end else begin
      case (state_q)
        PCGEN_BOOT: begin
          state_d = PCGEN_RUN;
        end
        PCGEN_RUN: begin
          if (fence_req_i) begin
            fence_pc_d = {fence_pc_i[ADDR_W-1:2], 2'b00};
            state_d    = PCGEN_FENCE;
          end else if (acc_s && btb_prd_vld_i) begin
            pc_d = btb_tgt_s;
          end else if (acc_s) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
          end else begin
            pc_d = pc_q;
          end
        end
        PCGEN_FENCE: begin
          if (fence_done_i) begin
            pc_d    = fence_pc_q;
            state_d = PCGEN_RUN;
          end else begin
            state_d = PCGEN_FENCE;
          end
        end
        default: begin
          state_d = PCGEN_BOOT;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state and PC.
  always_comb begin
    pc_vld_o     = (state_q == PCGEN_RUN);
    pc_o         = pc_q;
    prd_src_pc_o = pc_q;
    pc_prd_tkn_o = btb_prd_vld_i & (state_q == PCGEN_RUN);
    pc_prd_tgt_o = btb_tgt_s;
  end

`ifdef K423_PCGEN_PERF_EN
  k423_if_pcgen_perf u_perf (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .fetch_inc_i        (acc_s),
    .prd_tkn_inc_i      (acc_s & btb_prd_vld_i),
    .rdr_inc_i          (rdr_vld_i | flush_vld_i),
    .perf_fetch_cnt_o   (perf_fetch_cnt_o),
    .perf_prd_tkn_cnt_o (perf_prd_tkn_cnt_o),
    .perf_rdr_cnt_o     (perf_rdr_cnt_o)
  );
`endif

endmodule

// File: tb/tb_k423_if_pcgen.sv
// Scoreboard bench for k423_if_pcgen: a reference model pushes the expected PC/valid per cycle,
// popped and compared after each clock edge; directed checks cover the key scenarios.
module tb_k423_if_pcgen;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] prd_src_pc_o;
  logic        btb_prd_vld_i;
  logic [31:0] btb_prd_tgt_pc_i;
  logic        pc_vld_o;
  logic        pc_rdy_i;
  logic [31:0] pc_o;
  logic        pc_prd_tkn_o;
  logic [31:0] pc_prd_tgt_o;
  logic        rdr_vld_i;
  logic [31:0] rdr_pc_i;
  logic        flush_vld_i;
  logic [31:0] flush_pc_i;
  logic        fence_req_i;
  logic [31:0] fence_pc_i;
  logic        fence_done_i;
`ifdef K423_PCGEN_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_prd_tkn_cnt_o;
  logic [31:0] perf_rdr_cnt_o;
`endif

  k423_if_pcgen #(.ADDR_W(32), .RST_PC(RST_PC)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .prd_src_pc_o     (prd_src_pc_o),
    .btb_prd_vld_i    (btb_prd_vld_i),
    .btb_prd_tgt_pc_i (btb_prd_tgt_pc_i),
    .pc_vld_o         (pc_vld_o),
    .pc_rdy_i         (pc_rdy_i),
    .pc_o             (pc_o),
    .pc_prd_tkn_o     (pc_prd_tkn_o),
    .pc_prd_tgt_o     (pc_prd_tgt_o),
    .rdr_vld_i        (rdr_vld_i),
    .rdr_pc_i         (rdr_pc_i),
    .flush_vld_i      (flush_vld_i),
    .flush_pc_i       (flush_pc_i),
    .fence_req_i      (fence_req_i),
    .fence_pc_i       (fence_pc_i),
    .fence_done_i     (fence_done_i)
`ifdef K423_PCGEN_PERF_EN
    ,
    .perf_fetch_cnt_o   (perf_fetch_cnt_o),
    .perf_prd_tkn_cnt_o (perf_prd_tkn_cnt_o),
    .perf_rdr_cnt_o     (perf_rdr_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];

  // Reference model state: 0 boot, 1 run, 2 fence.
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_prd_cnt;
  logic [31:0] m_rdr_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state     = 0;
    m_pc        = RST_PC;
    m_fpc       = 32'h0;
    m_fetch_cnt = 32'h0;
    m_prd_cnt   = 32'h0;
    m_rdr_cnt   = 32'h0;
  endtask

  task automatic drive_idle();
    btb_prd_vld_i    = 1'b0;
    btb_prd_tgt_pc_i = 32'h0;
    pc_rdy_i         = 1'b1;
    rdr_vld_i        = 1'b0;
    rdr_pc_i         = 32'h0;
    flush_vld_i      = 1'b0;
    flush_pc_i       = 32'h0;
    fence_req_i      = 1'b0;
    fence_pc_i       = 32'h0;
    fence_done_i     = 1'b0;
  endtask

  // One clock: check combinational outputs, step the model, push expectation, compare after the edge.
  task automatic cyc(input string tag);
    logic        acc;
    logic [32:0] e;
    #1;
    check_val({tag, "_src"}, prd_src_pc_o, m_pc);
    check_val({tag, "_tkn"}, 32'(pc_prd_tkn_o), 32'(btb_prd_vld_i && (m_state == 1)));
    check_val({tag, "_tgt"}, pc_prd_tgt_o, btb_prd_tgt_pc_i & 32'hFFFF_FFFC);
    acc = (m_state == 1) && pc_rdy_i;
    if (acc) m_fetch_cnt = m_fetch_cnt + 32'd1;
    if (acc && btb_prd_vld_i) m_prd_cnt = m_prd_cnt + 32'd1;
    if (rdr_vld_i || flush_vld_i) m_rdr_cnt = m_rdr_cnt + 32'd1;
    if (flush_vld_i) begin
      m_pc = flush_pc_i & 32'hFFFF_FFFC; m_state = 1;
    end else if (rdr_vld_i) begin
      m_pc = rdr_pc_i & 32'hFFFF_FFFC; m_state = 1;
    end else if (m_state == 1 && fence_req_i) begin
      m_fpc = fence_pc_i & 32'hFFFF_FFFC; m_state = 2;
    end else if (m_state == 2 && fence_done_i) begin
      m_pc = m_fpc; m_state = 1;
    end else if (m_state == 1 && acc && btb_prd_vld_i) begin
      m_pc = btb_prd_tgt_pc_i & 32'hFFFF_FFFC;
    end else if (m_state == 1 && acc) begin
      m_pc = m_pc + 32'd4;
    end else if (m_state == 0) begin
      m_state = 1;
    end
    exp_q.push_back({(m_state == 1), m_pc});
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_pc"}, pc_o, e[31:0]);
      check_val({tag, "_vld"}, 32'(pc_vld_o), 32'(e[32]));
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    rst_n_i = 1'b0;
    #12;
    check_val("rst_pc", pc_o, RST_PC);
    check_val("rst_vld", 32'(pc_vld_o), 32'd0);
    rst_n_i = 1'b1;

    // Boot then sequential fetch.
    cyc("boot");
    check_val("boot_vld", 32'(pc_vld_o), 32'd1);
    check_val("boot_pc", pc_o, 32'h8000_0000);
    cyc("seq0");
    cyc("seq1");
    check_val("seq_pc8", pc_o, 32'h8000_0008);

    // Stall with valid held high.
    pc_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall");
    check_val("stall_pc", pc_o, 32'h8000_0008);
    check_val("stall_vld", 32'(pc_vld_o), 32'd1);
    pc_rdy_i = 1'b1;
    cyc("rel");
    check_val("rel_pc", pc_o, 32'h8000_000C);
    cyc("seq2");

    // BTB taken prediction at 0x8000_0010.
    btb_prd_vld_i    = 1'b1;
    btb_prd_tgt_pc_i = 32'h8000_0102;
    #1;
    check_val("btb_tkn", 32'(pc_prd_tkn_o), 32'd1);
    check_val("btb_tgt", pc_prd_tgt_o, 32'h8000_0100);
    cyc("btb");
    check_val("btb_pc", pc_o, 32'h8000_0100);
    btb_prd_vld_i = 1'b0;

    // Flush beats redirect, independent of ready; then redirect alone.
    pc_rdy_i    = 1'b0;
    flush_vld_i = 1'b1; flush_pc_i = 32'h0000_0200;
    rdr_vld_i   = 1'b1; rdr_pc_i   = 32'h8000_0040;
    cyc("flrdr");
    check_val("flrdr_pc", pc_o, 32'h0000_0200);
    flush_vld_i = 1'b0;
    cyc("rdr");
    check_val("rdr_pc", pc_o, 32'h8000_0040);
    rdr_vld_i = 1'b0;
    pc_rdy_i  = 1'b1;

    // Fence with resume after fence_done.
    fence_req_i = 1'b1; fence_pc_i = 32'h8000_0050;
    cyc("fence_in");
    fence_req_i = 1'b0;
    check_val("fence_vld", 32'(pc_vld_o), 32'd0);
    for (int i = 0; i < 4; i++) cyc("fence_wait");
    fence_done_i = 1'b1;
    cyc("fence_done");
    fence_done_i = 1'b0;
    check_val("fence_pc", pc_o, 32'h8000_0050);
    check_val("fence_out_vld", 32'(pc_vld_o), 32'd1);

    // Flush aborts an outstanding fence.
    fence_req_i = 1'b1; fence_pc_i = 32'h8000_0070;
    cyc("fence2_in");
    fence_req_i = 1'b0;
    cyc("fence2_wait");
    flush_vld_i = 1'b1; flush_pc_i = 32'h0000_0303;
    cyc("fence2_flush");
    flush_vld_i = 1'b0;
    check_val("fence2_flush_pc", pc_o, 32'h0000_0300);
    check_val("fence2_flush_vld", 32'(pc_vld_o), 32'd1);

    // Wrap at the top of the address space.
    rdr_vld_i = 1'b1; rdr_pc_i = 32'hFFFF_FFFF;
    cyc("wrap_rdr");
    rdr_vld_i = 1'b0;
    check_val("wrap_top", pc_o, 32'hFFFF_FFFC);
    cyc("wrap");
    check_val("wrap_pc", pc_o, 32'h0000_0000);

    // Reset in the middle of a fence; BOOT ignores a fence request.
    fence_req_i = 1'b1; fence_pc_i = 32'h8000_0060;
    cyc("fence3_in");
    fence_req_i = 1'b0;
    cyc("fence3_wait");
    rst_n_i = 1'b0;
    #1;
    check_val("midrst_pc", pc_o, RST_PC);
    check_val("midrst_vld", 32'(pc_vld_o), 32'd0);
    model_reset();
    @(posedge clk_i);
    #2;
    rst_n_i     = 1'b1;
    fence_req_i = 1'b1; fence_pc_i = 32'h8000_0090;
    cyc("boot2");
    fence_req_i = 1'b0;
    check_val("boot2_pc", pc_o, RST_PC);
    check_val("boot2_vld", 32'(pc_vld_o), 32'd1);
    cyc("boot2_seq");
    check_val("boot2_seq_pc", pc_o, RST_PC + 32'd4);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      pc_rdy_i         = 1'($urandom_range(0, 1));
      btb_prd_vld_i    = ($urandom_range(0, 3) == 0);
      btb_prd_tgt_pc_i = $urandom;
      rdr_vld_i        = ($urandom_range(0, 9) == 0);
      rdr_pc_i         = $urandom;
      flush_vld_i      = ($urandom_range(0, 14) == 0);
      flush_pc_i       = $urandom;
      fence_req_i      = ($urandom_range(0, 11) == 0);
      fence_pc_i       = $urandom;
      fence_done_i     = ($urandom_range(0, 2) == 0);
      cyc("rnd");
    end
    drive_idle();

`ifdef K423_PCGEN_PERF_EN
    check_val("perf_fetch", perf_fetch_cnt_o, m_fetch_cnt);
    check_val("perf_prd", perf_prd_tkn_cnt_o, m_prd_cnt);
    check_val("perf_rdr", perf_rdr_cnt_o, m_rdr_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
